// File: rtl/nr_sqrt_rsqrt_fixedpoint_if.sv
// Start/ready request bus for the Newton-Raphson sqrt / rsqrt unit.
interface nr_sqrt_rsqrt_fixedpoint_if #(
    parameter int N        = 16,
    parameter int ITER_MAX = 8
);
    localparam int CW = $clog2(ITER_MAX + 1);

    logic          start;
    logic          mode;
    logic [N-1:0]  X;
    logic [N-1:0]  result;
    logic          ready;
    logic          busy;
    logic          err;
    logic [CW-1:0] iter_count;

    modport master (
        output start, mode, X,
        input  result, ready, busy, err, iter_count
    );

    modport slave (
        input  start, mode, X,
        output result, ready, busy, err, iter_count
    );
endinterface

// File: rtl/nr_sqrt_rsqrt_fixedpoint.sv
// Iterative fixed-point Newton-Raphson sqrt(X) / 1/sqrt(X), Q(N-M).M unsigned.
// Define NR_EARLY_EXIT_EN to leave ITER as soon as r stops moving.
module nr_sqrt_rsqrt_fixedpoint #(
    parameter int N        = 16,
    parameter int M        = 8,
    parameter int ITER_MAX = 8
) (
    input logic                       clk,
    input logic                       rst,
    nr_sqrt_rsqrt_fixedpoint_if.slave bus
);
    localparam int CW = $clog2(ITER_MAX + 1);
    localparam int RW = 2 * N;
    // r keeps a few integer bits for 1/sqrt of the smallest operand
    localparam int F  = RW - M / 2 - 2;

    typedef enum logic [2:0] {IDLE, SEED, ITER, FINAL, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic          mode_q, mode_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [CW-1:0] iter_q, iter_d;

    int            p;
    int            s;
    logic [RW-1:0] r0;

    always_comb begin
        p = 0;
        for (int i = 0; i < N; i++) begin
            if (x_q[i]) p = i;
        end
        s  = (p - M + 1) >>> 1;
        r0 = RW'(1) << (F - s);
    end

    logic [N+RW-1:0]   xr;
    logic [N+2*RW-1:0] xrr;
    logic [RW+1:0]     t;
    logic [RW+1:0]     three;
    logic [RW+1:0]     h;
    logic [2*RW+1:0]   rh;
    logic [RW-1:0]     r_new;

    assign xr    = (N+RW)'(x_q) * (N+RW)'(r_q);
    assign xrr   = (N+2*RW)'(xr) * (N+2*RW)'(r_q);
    assign t     = (RW+2)'(xrr >> (M + F));
    assign three = (RW+2)'(3) << F;
    assign h     = (t > three) ? '0 : three - t;
    assign rh    = (2*RW+2)'(r_q) * (2*RW+2)'(h);
    assign r_new = RW'(rh >> (F + 1));

    logic last;
`ifdef NR_EARLY_EXIT_EN
    logic [RW-1:0] dr;
    assign dr   = (r_new > r_q) ? r_new - r_q : r_q - r_new;
    assign last = (dr <= RW'(1)) || (cnt_q == CW'(ITER_MAX - 1));
`else
    assign last = (cnt_q == CW'(ITER_MAX - 1));
`endif

    logic [N+RW:0] sq;
    logic [RW:0]   rs;
    logic [N-1:0]  sq_res;
    logic [N-1:0]  rs_res;

    // round to M fractional bits, saturate when the integer part spills
    always_comb begin
        sq     = (N+RW+1)'(xr) + ((N+RW+1)'(1) << (F - 1));
        rs     = (RW+1)'(r_q) + ((RW+1)'(1) << (F - M - 1));
        sq_res = ((sq >> (F + N)) != '0) ? '1 : N'(sq >> F);
        rs_res = ((rs >> (F - M + N)) != '0) ? '1 : N'(rs >> (F - M));
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        mode_d   = mode_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        err_d    = err_q;
        iter_d   = iter_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    x_d     = bus.X;
                    mode_d  = bus.mode;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEED;
                end
            end
            SEED: begin
                r_d   = r0;
                cnt_d = '0;
                if (x_q == '0) begin
                    result_d = mode_q ? '1 : '0;
                    err_d    = mode_q;
                    iter_d   = '0;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d   = r_new;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    iter_d  = cnt_q + CW'(1);
                    state_d = FINAL;
                end
            end
            FINAL: begin
                result_d = mode_q ? rs_res : sq_res;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            mode_q   <= 1'b0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            mode_q   <= mode_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            iter_q   <= iter_d;
        end
    end

    assign bus.result     = result_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_nr_sqrt_rsqrt_fixedpoint.sv
// Directed bench for nr_sqrt_rsqrt_fixedpoint against a real-arithmetic model.
// Honours NR_EARLY_EXIT_EN for iteration-count and latency expectations.
module tb_nr_sqrt_rsqrt_fixedpoint;
    localparam int N        = 16;
    localparam int M        = 8;
    localparam int ITER_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [N-1:0] cur_x     = '0;
    logic         cur_mode  = 1'b0;
    bit           cur_valid = 1'b0;

    nr_sqrt_rsqrt_fixedpoint_if #(.N(N), .ITER_MAX(ITER_MAX)) bus ();

    nr_sqrt_rsqrt_fixedpoint #(.N(N), .M(M), .ITER_MAX(ITER_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic real ideal(input logic [N-1:0] x, input logic m);
        real v;
        real y;
        v = $itor(x) / 256.0;
        y = m ? 256.0 / $sqrt(v) : $sqrt(v) * 256.0;
        if (y > 65535.0) y = 65535.0;
        return y;
    endfunction

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic chk_near(input string nm, input int got, input real want);
        real d;
        total++;
        d = $itor(got) - want;
        if (d < 0.0) d = -d;
        if (d > 2.0) begin
            bad++;
            $display("FAIL %s got=%0d want=%0.2f+-2", nm, got, want);
        end
    endtask

    // output checker: every cycle a finished result is on the bus
    always @(negedge clk) begin
        if (!rst && cur_valid && bus.ready) begin
            chk("busy_when_ready", bus.busy, 0);
            if (cur_x == '0) begin
                chk("zero_result", bus.result, cur_mode ? 65535 : 0);
                chk("zero_err", bus.err, cur_mode);
                chk("zero_iter", bus.iter_count, 0);
            end else begin
                chk_near("result", bus.result, ideal(cur_x, cur_mode));
                chk("err", bus.err, 0);
`ifdef NR_EARLY_EXIT_EN
                chk("iter_range",
                    (bus.iter_count >= 1 && bus.iter_count <= ITER_MAX), 1);
`else
                chk("iter_count", bus.iter_count, ITER_MAX);
`endif
            end
        end
    end

    task automatic start_op(input logic [N-1:0] x, input logic m);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.X     = x;
        bus.mode  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cur_x     = x;
        cur_mode  = m;
        cur_valid = 1'b1;
        chk("accept_ready_low", bus.ready, 0);
        chk("accept_busy", bus.busy, 1);
    endtask

    task automatic wait_ready(input int lat0, output int lat);
        lat = lat0;
        while (!bus.ready && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("ready_seen", bus.ready, 1);
        if (cur_x == '0) begin
            chk("latency_zero", lat, 2);
        end else begin
`ifdef NR_EARLY_EXIT_EN
            chk("latency", lat, 3 + int'(bus.iter_count));
`else
            chk("latency", lat, 3 + ITER_MAX);
`endif
        end
    endtask

    task automatic run(input logic [N-1:0] x, input logic m);
        int lat;
        start_op(x, m);
        wait_ready(1, lat);
        @(negedge clk);
    endtask

    logic [N-1:0] sweep [$];

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.mode  = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", bus.result, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_iter", bus.iter_count, 0);
        rst = 1'b0;

        run(16'd1024, 1'b0);
        chk_near("lit_sqrt_4", bus.result, 512.0);
        run(16'd1024, 1'b1);
        chk_near("lit_rsqrt_4", bus.result, 128.0);
        run(16'd1, 1'b1);
        chk_near("lit_rsqrt_1_256", bus.result, 4096.0);
        run(16'd0, 1'b1);
        chk("lit_rsqrt0_result", bus.result, 65535);
        chk("lit_rsqrt0_err", bus.err, 1);
        chk("lit_rsqrt0_iter", bus.iter_count, 0);
        run(16'd0, 1'b0);
        chk("lit_sqrt0_result", bus.result, 0);
        chk("lit_sqrt0_err", bus.err, 0);
        run(16'hFFFF, 1'b0);
        chk_near("lit_sqrt_max", bus.result, 4095.97);

        start_op(16'd256, 1'b0);
        wait_ready(1, lat);
        chk_near("lit_sqrt_1", bus.result, 256.0);
`ifdef NR_EARLY_EXIT_EN
        chk("early_exit", (bus.iter_count < ITER_MAX), 1);
`else
        chk("no_early_iter", bus.iter_count, ITER_MAX);
        chk("no_early_lat", lat, 3 + ITER_MAX);
`endif

        // second start while busy must be dropped
        start_op(16'd1024, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.X     = 16'd16;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_ready(3, lat);
        chk_near("lit_ignored_start", bus.result, 512.0);

        start_op(16'd1024, 1'b0);
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", bus.ready, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_err", bus.err, 0);
        rst = 1'b0;
        run(16'd256, 1'b0);
        chk_near("lit_after_rst", bus.result, 256.0);

        sweep = '{16'd0, 16'd1, 16'd2, 16'd16, 16'd64, 16'd100, 16'd256,
                  16'd300, 16'd1024, 16'd4095, 16'hFFFF};
        for (int i = 1; i < 40; i++) sweep.push_back(16'((i * 123) % 65536));
        for (int k = 0; k < 2; k++) begin
            foreach (sweep[j]) run(sweep[j], k[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nr_sqrt_rsqrt_fixedpoint.md
Name: nr_sqrt_rsqrt_fixedpoint

Overview:
Iterative fixed-point Newton-Raphson unit computing sqrt(X) or 1/sqrt(X) on an unsigned QI.M operand, selected per operation by `mode`.
It is the parametrised successor to the team's sqrt-only NR block. Additions:
- multiplier-only iteration, no divider
- leading-one seeding
- convergence early exit
- error flag and iteration-count reporting

It sits as a sequential math slave behind a start/ready handshake.

Parameters:
- N, 16, operand/result width in bits
- M, 8, fractional bits of X and result (Q(N-M).M, unsigned)
- ITER_MAX, 8, maximum NR iterations per operation (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only when not busy
- mode  in  1  0 = sqrt, 1 = rsqrt; captured on accepted start
- X  in  N  operand, captured on accepted start
- result  out  N  result in Q(N-M).M; valid while ready=1
- ready  out  1  result valid, level
- busy  out  1  operation in progress
- err  out  1  rsqrt of zero; valid while ready=1
- iter_count  out  $clog2(ITER_MAX+1)  iterations performed in last op; valid while ready=1

Behaviour:
- Reset: synchronous, active-high; clk single clock. Reset values: result=0, ready=0, busy=0, err=0, iter_count=0, state=IDLE. rst wins over every other input, including mid-operation; outputs clear the cycle after rst is sampled.
- States: IDLE → SEED → ITER → FINAL → DONE. DONE behaves as IDLE with ready=1.
- Accept: start=1 in IDLE/DONE. Same edge: capture X and mode, clear ready/err, set busy. start while busy is ignored; it is not queued.
- SEED (1 cycle):
  - p = index of leading one of X; e = p − M (signed).
  - Seed r0 = 2^(−floor((e+1)/2)), which guarantees r0·sqrt(X) ∈ [1/√2, √2].
  - X=0: skip ITER/FINAL. Next state DONE, iter_count=0. sqrt: result=0, err=0. rsqrt: result=all-ones, err=1.
- ITER (1 iteration/cycle): r ← r·(3 − X·r²)/2.
  - Internal r is unsigned, 2N bits, with enough fractional bits to hold 2^(−(N−M)/2) to ≥N significant bits.
  - Products are computed at full width, then truncated.
  - Exit to FINAL when |r_new − r_old| ≤ 1 internal LSB, or when the iteration count reaches ITER_MAX.
- FINAL (1 cycle):
  - sqrt: result = X·r.
  - rsqrt: result = r.
  - Both are rounded to M fractional bits, then saturated to all-ones on overflow (saturation alone does not set err).
- DONE: ready=1, busy=0. result, err and iter_count are held until the next accepted start or rst.
- Latency, start edge to ready=1: 3 + k cycles, k = iterations performed (1..ITER_MAX). Zero operand: 2 cycles.
- Accuracy: |result − ideal·2^M| ≤ 2 LSB for every non-saturating X, both modes.

Optional Feature:
- Macro: NR_EARLY_EXIT_EN.
- Defined: convergence early exit as above; latency is data-dependent.
- Undefined: ITER always runs exactly ITER_MAX iterations and iter_count=ITER_MAX. Latency is fixed at 3+ITER_MAX cycles (zero operand still 2). Accuracy rule unchanged.

Test Plan:
- Basic sqrt: X=1024 (4.0), mode=0 → result 512±2, err=0, ready within 3+ITER_MAX cycles, busy low once ready rises.
- Basic rsqrt: X=1024 (4.0), mode=1 → result 128±2. X=1 (1/256), mode=1 → result 4096±2 (16.0).
- Zero operand:
  - X=0, mode=1 → result 0xFFFF, err=1, iter_count=0, ready exactly 2 cycles after start.
  - X=0, mode=0 → result 0, err=0.
- Extremes and sweep: X=0xFFFF, mode=0 → result 4095±2. Sweep the same 50-value set as the sqrt-only bench (0, 1, 2, 16, 64, 100, 256, 300, 1024, 4095, 0xFFFF, (i·123) mod 65536) in both modes → all within 2 LSB.
- Handshake:
  - start re-pulsed with X=16 while busy on X=1024 → ignored, final result 512±2.
  - New start in DONE → ready low next cycle.
- Reset mid-op: rst asserted 2 cycles after start → next cycle ready=0, busy=0, result=0. Subsequent start with X=256, mode=0 → 256±2.
- Early exit: X=256, mode=0 with NR_EARLY_EXIT_EN → iter_count < ITER_MAX. Without it → iter_count=ITER_MAX, latency 3+ITER_MAX.
